// File: rtl/mem_pkg.sv
// Shared definitions for the memory controller slice: width defaults, FSM states, port ids.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 16;

    // Consecutive data-port grants allowed while fetch waits before fetch wins
    localparam int ARB_DM_MAX = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/mem_arb.sv
// Two-port arbiter: data port has priority, fetch forced in after ARB_DM_MAX back-to-back dm wins.
// Latency: grants are combinational from requests, idle and the starvation counter.
// Backpressure: no grant while i_idle is low; requesters hold until granted.
module mem_arb
    import mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_idle,
    input  logic i_if_req,
    input  logic i_dm_req,
    output logic o_if_gnt,
    output logic o_dm_gnt
);

    logic [1:0] r_dm_cnt;
    logic       w_if_turn;

    // Fetch has waited through enough dm grants: it takes the next slot
    assign w_if_turn = i_if_req && (r_dm_cnt == 2'(ARB_DM_MAX));
    assign o_dm_gnt  = i_idle && i_dm_req && !w_if_turn;
    assign o_if_gnt  = i_idle && i_if_req && !o_dm_gnt;

    // Count dm grants taken while fetch is waiting; any fetch grant or idle fetch clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dm_cnt <= 2'd0;
        end else if (!i_if_req || o_if_gnt) begin
            r_dm_cnt <= 2'd0;
        end else if (o_dm_gnt) begin
            r_dm_cnt <= r_dm_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Single-array memory controller shared by an instruction-fetch port and a data port.
// Latency: gnt in cycle N, active-low strobe in N+1, ack pulse and registered data in N+2.
// Backpressure: one access in flight; gnt withheld outside IDLE so requesters hold their request.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              proc_rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy
);

    state_t            r_state;
    logic              r_port;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_in;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_if_ack;
    logic              r_dm_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              w_idle;
    logic              w_if_gnt;
    logic              w_dm_gnt;

    // Grants are suppressed while reset is held so nothing is accepted into a forced-idle FSM
    assign w_idle = (r_state == ST_IDLE) && !proc_rst;

    mem_arb u_arb (
        .clk      (clk),
        .rst      (proc_rst),
        .i_idle   (w_idle),
        .i_if_req (if_req),
        .i_dm_req (dm_req),
        .o_if_gnt (w_if_gnt),
        .o_dm_gnt (w_dm_gnt)
    );

    // FSM plus datapath: latch the granted request, drive one strobe cycle, return data and ack
    always_ff @(posedge clk or posedge proc_rst) begin
        if (proc_rst) begin
            r_state     <= ST_IDLE;
            r_port      <= PORT_IF;
            r_mem_addr  <= '0;
            r_mem_in    <= '0;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b1;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_dm_gnt) begin
                        r_port     <= PORT_DM;
                        r_mem_addr <= dm_addr;
                        if (dm_we) begin
                            r_mem_in    <= dm_wdata;
                            r_mem_write <= 1'b0;
                            r_state     <= ST_WRITE;
                        end else begin
                            r_mem_read <= 1'b0;
                            r_state    <= ST_READ;
                        end
                    end else if (w_if_gnt) begin
                        r_port     <= PORT_IF;
                        r_mem_addr <= if_addr;
                        r_mem_read <= 1'b0;
                        r_state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Array drove mem_out on the falling edge mid-cycle; capture it now
                    r_state <= ST_IDLE;
                    if (r_port == PORT_DM) begin
                        r_dm_rdata <= mem_out;
                        r_dm_ack   <= 1'b1;
                    end else begin
                        r_if_rdata <= mem_out;
                        r_if_ack   <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_state  <= ST_IDLE;
                    r_dm_ack <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_gnt    = w_if_gnt;
    assign dm_gnt    = w_dm_gnt;
    assign if_ack    = r_if_ack;
    assign dm_ack    = r_dm_ack;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_in    = r_mem_in;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a falling-edge memory array model.
// Latency: checks gnt N, strobe N+1, ack N+2 on each access.
// Backpressure: exercises held requests, arbitration order and reset mid-access.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        proc_rst;
    logic        if_req;
    logic [4:0]  if_addr;
    logic        if_gnt;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [4:0]  dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_ack;
    logic [15:0] dm_rdata;
    logic [4:0]  mem_addr;
    logic [15:0] mem_in;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_out;
    logic        busy;

    logic [15:0] tb_mem [32];

    int n_cmp = 0;
    int n_err = 0;
    int n_gnt = 0;
    int n_stb = 0;
    int n_ack = 0;
    int n_excl_bad = 0;
    int n_idle_bad = 0;
    int n_dbl_gnt = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(5), .DATA_W(16)) dut (
        .clk       (clk),
        .proc_rst  (proc_rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .mem_addr  (mem_addr),
        .mem_in    (mem_in),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_out   (mem_out),
        .busy      (busy)
    );

    // Memory array: preloaded while reset is high, writes and read data update on the falling edge
    always @(negedge clk) begin
        if (proc_rst) begin
            for (int i = 0; i < 32; i++) tb_mem[i] <= 16'h0000;
            tb_mem[3] <= 16'h3C3C;
            tb_mem[7] <= 16'h7E57;
            mem_out   <= 16'h0000;
        end else begin
            if (!mem_write) tb_mem[mem_addr] <= mem_in;
            mem_out <= tb_mem[mem_addr];
        end
    end

    // Per-cycle protocol monitor: strobe exclusivity, idle strobes, grant/strobe/ack tallies
    always @(negedge clk) begin
        if (!proc_rst) begin
            if (!mem_read && !mem_write) n_excl_bad++;
            if (!busy && !(mem_read && mem_write)) n_idle_bad++;
            if (if_gnt && dm_gnt) n_dbl_gnt++;
            if (if_gnt || dm_gnt) n_gnt++;
            if (!mem_read || !mem_write) n_stb++;
            if (if_ack || dm_ack) n_ack++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dm_access(input string tag, input logic we, input logic [4:0] a,
                             input logic [15:0] d, input logic [15:0] exp_rd);
        int n;
        n = 0;
        dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d;
        @(negedge clk);
        while (!dm_gnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_gnt"}, 32'(dm_gnt), 1);
        check_val({tag, "_lat"}, 32'(n), 0);
        check_val({tag, "_ifgnt"}, 32'(if_gnt), 0);
        @(posedge clk); #1;
        dm_req = 1'b0;
        @(negedge clk);
        check_val({tag, "_stb"}, 32'({mem_read, mem_write}), we ? 32'h2 : 32'h1);
        check_val({tag, "_addr"}, 32'(mem_addr), 32'(a));
        check_val({tag, "_busy"}, 32'(busy), 1);
        check_val({tag, "_gnt_blk"}, 32'(dm_gnt), 0);
        if (we) check_val({tag, "_wdata"}, 32'(mem_in), 32'(d));
        @(negedge clk);
        check_val({tag, "_ack"}, 32'(dm_ack), 1);
        check_val({tag, "_idle"}, 32'({busy, mem_read, mem_write}), 32'h3);
        if (!we) check_val({tag, "_rdata"}, 32'(dm_rdata), 32'(exp_rd));
        @(posedge clk); #1;
        check_val({tag, "_ack_pulse"}, 32'(dm_ack), 0);
    endtask

    task automatic if_access(input string tag, input logic [4:0] a, input logic [15:0] exp_rd);
        int n;
        n = 0;
        if_req = 1'b1; if_addr = a;
        @(negedge clk);
        while (!if_gnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_gnt"}, 32'(if_gnt), 1);
        check_val({tag, "_lat"}, 32'(n), 0);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        check_val({tag, "_stb"}, 32'({mem_read, mem_write}), 32'h1);
        check_val({tag, "_addr"}, 32'(mem_addr), 32'(a));
        check_val({tag, "_ack_early"}, 32'(if_ack), 0);
        @(negedge clk);
        check_val({tag, "_ack"}, 32'(if_ack), 1);
        check_val({tag, "_rdata"}, 32'(if_rdata), 32'(exp_rd));
        @(posedge clk); #1;
        check_val({tag, "_ack_pulse"}, 32'(if_ack), 0);
    endtask

    initial begin
        int n;
        int k;
        int a0;
        int g0;
        int s0;
        logic [5:0] seq;

        proc_rst = 1'b1;
        if_req = 1'b0; if_addr = 5'd0;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 5'd5; dm_wdata = 16'hA5A5;

        // Reset values with a data request already pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_strobes", 32'({mem_read, mem_write}), 32'h3);
        check_val("rst_addr_in", 32'({mem_addr, mem_in}), 0);
        check_val("rst_gnt", 32'({if_gnt, dm_gnt}), 0);
        check_val("rst_ack", 32'({if_ack, dm_ack}), 0);
        check_val("rst_rdata", 32'({if_rdata, dm_rdata}), 0);
        check_val("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        proc_rst = 1'b0;

        // Write 0xA5A5 to word 5, granted in the first cycle after reset release
        dm_access("wr5", 1'b1, 5'd5, 16'hA5A5, 16'h0000);
        check_val("wr_keeps_rdata", 32'(dm_rdata), 0);
        // Read it back
        dm_access("rd5", 1'b0, 5'd5, 16'h0000, 16'hA5A5);
        check_val("rd5_if_untouched", 32'(if_rdata), 0);

        // Both ports held: expect dm, dm, if, dm, dm, if at one grant per 2 cycles
        if_addr = 5'd7; if_req = 1'b1;
        dm_we = 1'b0; dm_addr = 5'd5; dm_req = 1'b1;
        seq = 6'd0; k = 0; n = 0; a0 = n_ack;
        while (k < 6 && n < 40) begin
            @(negedge clk);
            n++;
            if (dm_gnt) begin
                seq = {seq[4:0], 1'b1};
                k++;
            end else if (if_gnt) begin
                seq = {seq[4:0], 1'b0};
                k++;
            end
        end
        @(posedge clk); #1;
        if_req = 1'b0; dm_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("arb_count", 32'(k), 6);
        check_val("arb_order", 32'(seq), 32'h36);
        check_val("arb_cycles", 32'(n), 11);
        check_val("arb_acks", 32'(n_ack - a0), 6);
        check_val("arb_if_rdata", 32'(if_rdata), 32'h7E57);
        check_val("arb_dm_rdata", 32'(dm_rdata), 32'hA5A5);
        check_val("stb_per_gnt", 32'(n_stb), 32'(n_gnt));

        // Reset pulsed during a dm READ while a fetch request waits
        g0 = n_gnt; s0 = n_stb; a0 = n_ack;
        if_addr = 5'd3; if_req = 1'b1;
        dm_we = 1'b0; dm_addr = 5'd5; dm_req = 1'b1;
        n = 0;
        @(negedge clk);
        while (!dm_gnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("abort_gnt", 32'(dm_gnt), 1);
        @(posedge clk); #1;
        dm_req = 1'b0;
        #1;
        check_val("abort_pre_rd", 32'(mem_read), 0);
        proc_rst = 1'b1;
        #1;
        check_val("abort_strobes", 32'({mem_read, mem_write}), 32'h3);
        check_val("abort_busy", 32'(busy), 0);
        check_val("abort_addr", 32'(mem_addr), 0);
        check_val("abort_rdata", 32'({if_rdata, dm_rdata}), 0);
        check_val("abort_gnt_hold", 32'({if_gnt, dm_gnt}), 0);
        @(posedge clk);
        @(negedge clk);
        check_val("abort_no_ack", 32'({if_ack, dm_ack}), 0);
        @(posedge clk); #1;
        proc_rst = 1'b0;
        check_val("abort_ack_cnt", 32'(n_ack - a0), 0);

        // Pending fetch of word 3 re-arbitrates immediately after release
        if_access("if3", 5'd3, 16'h3C3C);
        check_val("if3_dm_rdata", 32'(dm_rdata), 0);

        repeat (2) @(posedge clk);
        #1;
        check_val("strobe_excl", 32'(n_excl_bad), 0);
        check_val("idle_strobes", 32'(n_idle_bad), 0);
        check_val("single_gnt", 32'(n_dbl_gnt), 0);
        check_val("stb_per_gnt_abort", 32'(n_stb - s0), 32'(n_gnt - g0 - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
